// File: rtl/debounce_pkg.sv
// Shared types and constants for the debounce_sync input conditioner.
// Defining DEBOUNCE_SYNC3_EN switches the synchroniser from two to three flops.
package debounce_pkg;

  typedef enum logic {
    STABLE = 1'b0,
    WAIT   = 1'b1
  } state_t;

`ifdef DEBOUNCE_SYNC3_EN
  localparam int SYNC_STAGES = 3;
`else
  localparam int SYNC_STAGES = 2;
`endif

  // Counter must hold CNT_MAX-1; a one-bit floor keeps the vector legal.
  function automatic int countWidth(input int maxCount);
    if (maxCount <= 2) return 1;
    return $clog2(maxCount);
  endfunction

endpackage

// File: rtl/debounce_sync_sync_ff.sv
// Parameterised-depth single-bit synchroniser with async active-low reset.
// Reusable for any asynchronous level entering the clock domain.
module sync_ff
  import debounce_pkg::*;
#(
  parameter int   DEPTH = 2,
  parameter logic INIT  = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] stages_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stages_q <= {DEPTH{INIT}};
    end else begin
      stages_q <= {stages_q[DEPTH-2:0], d_i};
    end
  end

  assign q_o = stages_q[DEPTH-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronises a raw asynchronous level and filters it with a stable-count FSM.
// Build with DEBOUNCE_SYNC3_EN for a three-flop synchroniser (one extra cycle latency).
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int   CNT_MAX = 4,
  parameter logic INIT    = 1'b0
) (
  input  logic CLK,
  input  logic CLR_N,
  input  logic D,
  output logic Q,
  output logic RISE,
  output logic FALL
);

  localparam int CNT_W = countWidth(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  logic             syncLevel;
  state_t           state_q;
  logic [CNT_W-1:0] count_q;
  logic             level_q;
  logic             rise_q;
  logic             fall_q;

  sync_ff #(
    .DEPTH(SYNC_STAGES),
    .INIT (INIT)
  ) uSync (
    .clk_i (CLK),
    .rst_ni(CLR_N),
    .d_i   (D),
    .q_o   (syncLevel)
  );

  // The count restarts whenever the synchronised level agrees with Q again,
  // so only an uninterrupted run of CNT_MAX differing samples flips Q.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q <= STABLE;
      count_q <= '0;
      level_q <= INIT;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state_q)
        STABLE: begin
          if (syncLevel != level_q) begin
            state_q <= WAIT;
            count_q <= CNT_W'(1);
          end else begin
            count_q <= '0;
          end
        end
        WAIT: begin
          if (syncLevel == level_q) begin
            state_q <= STABLE;
            count_q <= '0;
          end else if (count_q == CNT_LAST) begin
            level_q <= syncLevel;
            rise_q  <= syncLevel;
            fall_q  <= ~syncLevel;
            state_q <= STABLE;
            count_q <= '0;
          end else begin
            count_q <= count_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign Q    = level_q;
  assign RISE = rise_q;
  assign FALL = fall_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Self-checking bench for debounce_sync: vector tables fed through a scoreboard queue.
// Expected latencies follow DEBOUNCE_SYNC3_EN when the bench is built with it.
module tb_debounce_sync;

`ifdef DEBOUNCE_SYNC3_EN
  localparam int SYNC_DEPTH = 3;
`else
  localparam int SYNC_DEPTH = 2;
`endif
  localparam int CNT_MAX  = 4;
  localparam int LAT      = CNT_MAX + SYNC_DEPTH - 1;
  localparam int LAT2     = 2 + SYNC_DEPTH - 1;

  typedef struct {
    logic       d;
    logic [2:0] exp;
    string      name;
  } vec_t;

  logic clk;
  logic clrN;
  logic d, q, rise, fall;
  logic d2, q2, rise2, fall2;

  vec_t       vecs[$];
  logic [2:0] scoreboard[$];
  int         errors;
  int         checks;

  debounce_sync #(.CNT_MAX(CNT_MAX), .INIT(1'b0)) dut (
    .CLK(clk), .CLR_N(clrN), .D(d), .Q(q), .RISE(rise), .FALL(fall)
  );

  debounce_sync #(.CNT_MAX(2), .INIT(1'b0)) dut2 (
    .CLK(clk), .CLR_N(clrN), .D(d2), .Q(q2), .RISE(rise2), .FALL(fall2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, finished=0 required=1");
    $fatal(1);
  end

  function automatic void addVec(input logic dv, input logic [2:0] expv, input string nm);
    vec_t v;
    v.d    = dv;
    v.exp  = expv;
    v.name = nm;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input logic [2:0] actual, input logic [2:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: Q/RISE/FALL got=%b expected=%b at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Each record's input is driven just after an edge; its expectation is
  // queued then and retired once the following edge has produced outputs.
  task automatic applyStimulus(input bit useDut2);
    logic [2:0] expv;
    for (int i = 0; i < vecs.size(); i++) begin
      if (useDut2) d2 = vecs[i].d;
      else         d  = vecs[i].d;
      scoreboard.push_back(vecs[i].exp);
      @(posedge clk);
      #1;
      expv = scoreboard.pop_front();
      checkOutput(vecs[i].name, useDut2 ? {q2, rise2, fall2} : {q, rise, fall}, expv);
    end
    vecs.delete();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    clrN   = 1'b0;
    d      = 1'b1;
    d2     = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("resetHold", {q, rise, fall}, 3'b000);
    end
    d    = 1'b0;
    clrN = 1'b1;

    for (int k = 0; k < 3; k++) addVec(1'b0, 3'b000, "idle");
    applyStimulus(1'b0);

    for (int k = 0; k < LAT + 3; k++) addVec(1'b1, {k >= LAT, k == LAT, 1'b0}, "cleanRise");
    applyStimulus(1'b0);

    for (int k = 0; k < LAT + 3; k++) addVec(1'b0, {k < LAT, 1'b0, k == LAT}, "cleanFall");
    applyStimulus(1'b0);

    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 3; k++) addVec(1'b1, 3'b000, "bounceHigh");
      for (int k = 0; k < 2; k++) addVec(1'b0, 3'b000, "bounceLow");
    end
    applyStimulus(1'b0);

    for (int k = 0; k < 6; k++) addVec((k % 2 == 0) ? 1'b1 : 1'b0, 3'b000, "toggle");
    for (int k = 0; k < LAT + 3; k++) addVec(1'b1, {k >= LAT, k == LAT, 1'b0}, "settleRise");
    applyStimulus(1'b0);

    // Start a fall, then hit reset between edges while the filter is counting.
    d = 1'b0;
    for (int k = 0; k < 4; k++) @(posedge clk);
    #1;
    checkOutput("midWaitPre", {q, rise, fall}, 3'b100);
    #3;
    clrN = 1'b0;
    #1;
    checkOutput("midWaitReset", {q, rise, fall}, 3'b000);
    @(posedge clk);
    #1;
    clrN = 1'b1;
    for (int k = 0; k < 4; k++) addVec(1'b0, 3'b000, "postReset");
    applyStimulus(1'b0);

    for (int k = 0; k < LAT2 + 3; k++) addVec(1'b1, {k >= LAT2, k == LAT2, 1'b0}, "cnt2Rise");
    applyStimulus(1'b1);
    for (int k = 0; k < LAT2 + 3; k++) addVec(1'b0, {k < LAT2, 1'b0, k == LAT2}, "cnt2Fall");
    applyStimulus(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
